// File: rtl/rop3_arb_pkg.sv
// Shared types for the two-requester ROP3 arbiter: requester ids, the in-flight
// tag record and the fixed datapath latency.
package rop3_arb_pkg;

   localparam int ROP3_LAT = 2;

   typedef enum logic {
      REQ_A = 1'b0,
      REQ_B = 1'b1
   } req_id_t;

   typedef struct packed {
      logic    vld;
      req_id_t id;
   } tag_t;

endpackage

// File: rtl/rop3_arb2_if.sv
// Bundle of requester handshakes, datapath issue/result and response signals.
// Counter ports exist only when ROP3_ARB_STATS_EN is defined.
interface rop3_arb2_if #(parameter int N = 8);

   logic         hold;
   logic         a_valid;
   logic         a_ready;
   logic [N-1:0] a_p;
   logic [N-1:0] a_s;
   logic [N-1:0] a_d;
   logic [7:0]   a_mode;
   logic         b_valid;
   logic         b_ready;
   logic [N-1:0] b_p;
   logic [N-1:0] b_s;
   logic [N-1:0] b_d;
   logic [7:0]   b_mode;
   logic [N-1:0] rop_p;
   logic [N-1:0] rop_s;
   logic [N-1:0] rop_d;
   logic [7:0]   rop_mode;
   logic [N-1:0] rop_result;
   logic         rsp_a_valid;
   logic         rsp_b_valid;
   logic [N-1:0] rsp_data;
`ifdef ROP3_ARB_STATS_EN
   logic         cnt_clr;
   logic [15:0]  cnt_a;
   logic [15:0]  cnt_b;
`endif

   // Environment side: requesters plus the datapath result.
   modport master (
      output hold, a_valid, a_p, a_s, a_d, a_mode,
      output b_valid, b_p, b_s, b_d, b_mode, rop_result,
      input  a_ready, b_ready, rop_p, rop_s, rop_d, rop_mode,
      input  rsp_a_valid, rsp_b_valid, rsp_data
`ifdef ROP3_ARB_STATS_EN
      , output cnt_clr
      , input  cnt_a, cnt_b
`endif
   );

   // Arbiter side.
   modport slave (
      input  hold, a_valid, a_p, a_s, a_d, a_mode,
      input  b_valid, b_p, b_s, b_d, b_mode, rop_result,
      output a_ready, b_ready, rop_p, rop_s, rop_d, rop_mode,
      output rsp_a_valid, rsp_b_valid, rsp_data
`ifdef ROP3_ARB_STATS_EN
      , input  cnt_clr
      , output cnt_a, cnt_b
`endif
   );

endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin grant with hold; remembers the last requester served.
module rr_arb2
   import rop3_arb_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] req,
   input  logic       hold,
   input  logic       accept,
   output logic [1:0] gnt,
   output req_id_t    gnt_id
);

   req_id_t last_gnt_q;
   req_id_t last_gnt_d;

   // On a tie the requester not served last wins; history moves only on a transfer.
   always_comb begin
      gnt = 2'b00;
      if (!hold) begin
         case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = (last_gnt_q == REQ_A) ? 2'b10 : 2'b01;
            default: gnt = 2'b00;
         endcase
      end
      gnt_id     = gnt[1] ? REQ_B : REQ_A;
      last_gnt_d = accept ? gnt_id : last_gnt_q;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         last_gnt_q <= REQ_B;
      end else begin
         last_gnt_q <= last_gnt_d;
      end
   end

endmodule

// File: rtl/rop3_arb2.sv
// Shares one ROP3 datapath between requesters A and B and routes each result
// back to its originator. Optional transfer counters under ROP3_ARB_STATS_EN.
module rop3_arb2
   import rop3_arb_pkg::*;
#(
   parameter int N   = 8,
   parameter int LAT = ROP3_LAT
) (
   input  logic      clk,
   input  logic      reset,
   rop3_arb2_if.slave bus
);

   logic [1:0]   req;
   logic [1:0]   gnt;
   req_id_t      gnt_id;
   logic         accept;
   logic [N-1:0] p_mux;
   logic [N-1:0] s_mux;
   logic [N-1:0] d_mux;
   logic [7:0]   mode_mux;
   tag_t         tag_q [LAT];
   tag_t         tag_d [LAT];

   assign req    = {bus.b_valid, bus.a_valid};
   assign accept = |(gnt & req);

   rr_arb2 u_arb (
      .clk    (clk),
      .reset  (reset),
      .req    (req),
      .hold   (bus.hold),
      .accept (accept),
      .gnt    (gnt),
      .gnt_id (gnt_id)
   );

   // Idle cycles issue mode 0, which the datapath turns into a harmless zero.
   always_comb begin
      p_mux    = '0;
      s_mux    = '0;
      d_mux    = '0;
      mode_mux = '0;
      if (gnt[0]) begin
         p_mux    = bus.a_p;
         s_mux    = bus.a_s;
         d_mux    = bus.a_d;
         mode_mux = bus.a_mode;
      end else if (gnt[1]) begin
         p_mux    = bus.b_p;
         s_mux    = bus.b_s;
         d_mux    = bus.b_d;
         mode_mux = bus.b_mode;
      end
   end

   assign bus.a_ready  = gnt[0];
   assign bus.b_ready  = gnt[1];
   assign bus.rop_p    = p_mux;
   assign bus.rop_s    = s_mux;
   assign bus.rop_d    = d_mux;
   assign bus.rop_mode = mode_mux;

   always_comb begin
      tag_d[0] = '{vld: accept, id: gnt_id};
      for (int i = 1; i < LAT; i++) begin
         tag_d[i] = tag_q[i-1];
      end
   end

   // Tags are cleared on reset so results already inside the datapath are dropped.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < LAT; i++) begin
            tag_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < LAT; i++) begin
            tag_q[i] <= tag_d[i];
         end
      end
   end

   assign bus.rsp_a_valid = tag_q[LAT-1].vld && (tag_q[LAT-1].id == REQ_A);
   assign bus.rsp_b_valid = tag_q[LAT-1].vld && (tag_q[LAT-1].id == REQ_B);
   assign bus.rsp_data    = bus.rop_result;

`ifdef ROP3_ARB_STATS_EN
   logic [15:0] cnt_a_q;
   logic [15:0] cnt_a_d;
   logic [15:0] cnt_b_q;
   logic [15:0] cnt_b_d;

   // Clear wins over a same-cycle transfer; counts stick at all-ones.
   always_comb begin
      cnt_a_d = cnt_a_q;
      cnt_b_d = cnt_b_q;
      if (bus.cnt_clr) begin
         cnt_a_d = '0;
         cnt_b_d = '0;
      end else begin
         if (accept && (gnt_id == REQ_A) && (cnt_a_q != 16'hFFFF)) begin
            cnt_a_d = cnt_a_q + 16'd1;
         end
         if (accept && (gnt_id == REQ_B) && (cnt_b_q != 16'hFFFF)) begin
            cnt_b_d = cnt_b_q + 16'd1;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_a_q <= '0;
         cnt_b_q <= '0;
      end else begin
         cnt_a_q <= cnt_a_d;
         cnt_b_q <= cnt_b_d;
      end
   end

   assign bus.cnt_a = cnt_a_q;
   assign bus.cnt_b = cnt_b_q;
`endif

endmodule

// File: tb/tb_rop3_arb2.sv
// Scoreboard bench for rop3_arb2 with a two-stage ROP3 datapath model.
// Counter checks run when ROP3_ARB_STATS_EN is defined.
module tb_rop3_arb2;
   import rop3_arb_pkg::*;

   typedef struct {
      bit         id;
      logic [7:0] data;
      int         due;
   } exp_t;

   logic clk = 1'b0;
   logic reset;
   int   cyc = 0;
   int   errors = 0;
   int   checks = 0;
   exp_t sb[$];
   bit   model_last_b;
   logic [7:0] dp_stage;
   logic [7:0] dp_out;
`ifdef ROP3_ARB_STATS_EN
   int   exp_cnt_a;
   int   exp_cnt_b;
`endif

   rop3_arb2_if #(.N(8)) bus ();

   rop3_arb2 #(.N(8)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Each result bit selects the mode bit indexed by {P,S,D}.
   function automatic logic [7:0] rop3(input logic [7:0] p, input logic [7:0] s,
                                       input logic [7:0] d, input logic [7:0] mode);
      logic [7:0] r;
      for (int i = 0; i < 8; i++) begin
         r[i] = mode[{p[i], s[i], d[i]}];
      end
      return r;
   endfunction

   always @(posedge clk) begin
      dp_stage <= rop3(bus.rop_p, bus.rop_s, bus.rop_d, bus.rop_mode);
      dp_out   <= dp_stage;
   end
   assign bus.rop_result = dp_out;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic note_fail(input string name, input int act, input int exp);
      checks++;
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
   endtask

   task automatic do_reset(input int n);
      @(negedge clk);
      #1;
      bus.a_valid = 1'b0;
      bus.b_valid = 1'b0;
      bus.hold    = 1'b0;
      reset       = 1'b1;
      sb.delete();
      model_last_b = 1'b1;
`ifdef ROP3_ARB_STATS_EN
      exp_cnt_a = 0;
      exp_cnt_b = 0;
`endif
      repeat (n) @(negedge clk);
      #1;
      check("reset_rsp_a", bus.rsp_a_valid, 1'b0);
      check("reset_rsp_b", bus.rsp_b_valid, 1'b0);
      reset = 1'b0;
   endtask

   // One cycle of requester activity; the model picks the winner from scratch.
   task automatic apply_stimulus(input bit av, input bit bv, input bit h,
                                 input logic [7:0] ap, input logic [7:0] as_,
                                 input logic [7:0] ad, input logic [7:0] am,
                                 input logic [7:0] bp, input logic [7:0] bs,
                                 input logic [7:0] bd, input logic [7:0] bm);
      bit win_a;
      bit win_b;
      logic [7:0] exp_mode;
      @(negedge clk);
      #1;
      bus.a_valid = av;  bus.b_valid = bv;  bus.hold = h;
      bus.a_p = ap;  bus.a_s = as_;  bus.a_d = ad;  bus.a_mode = am;
      bus.b_p = bp;  bus.b_s = bs;   bus.b_d = bd;  bus.b_mode = bm;
      #1;
      win_a = !h && av && (!bv || model_last_b);
      win_b = !h && bv && (!av || !model_last_b);
      exp_mode = win_a ? am : (win_b ? bm : 8'h00);
      check("a_ready", bus.a_ready, win_a);
      check("b_ready", bus.b_ready, win_b);
      check("rop_mode", bus.rop_mode, exp_mode);
`ifdef ROP3_ARB_STATS_EN
      check("cnt_a", bus.cnt_a, exp_cnt_a);
      check("cnt_b", bus.cnt_b, exp_cnt_b);
      if (bus.cnt_clr) begin
         exp_cnt_a = 0;
         exp_cnt_b = 0;
      end else begin
         if (win_a && exp_cnt_a < 65535) exp_cnt_a++;
         if (win_b && exp_cnt_b < 65535) exp_cnt_b++;
      end
`endif
      if (win_a) begin
         sb.push_back('{id: 1'b0, data: rop3(ap, as_, ad, am), due: cyc + 2});
         model_last_b = 1'b0;
      end else if (win_b) begin
         sb.push_back('{id: 1'b1, data: rop3(bp, bs, bd, bm), due: cyc + 2});
         model_last_b = 1'b1;
      end
   endtask

   task automatic idle(input int n);
      repeat (n) apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   // Monitor: every response must match the oldest outstanding issue, on time.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (reset !== 1'b0) continue;
         while (sb.size() > 0 && sb[0].due < cyc) begin
            e = sb.pop_front();
            note_fail("rsp_missing_due", cyc, e.due);
         end
         if (bus.rsp_a_valid && bus.rsp_b_valid) note_fail("rsp_both_valid", 2, 1);
         if (bus.rsp_a_valid || bus.rsp_b_valid) begin
            if (sb.size() == 0) begin
               note_fail("rsp_unexpected", 1, 0);
            end else begin
               e = sb.pop_front();
               check("rsp_cycle", cyc, e.due);
               check("rsp_id_b", bus.rsp_b_valid, e.id);
               check("rsp_data", bus.rsp_data, e.data);
            end
         end
      end
   end

   initial begin
      #(3_000_000);
      note_fail("watchdog_timeout", 1, 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      reset = 1'b1;
      bus.hold = 1'b0;  bus.a_valid = 1'b0;  bus.b_valid = 1'b0;
      bus.a_p = '0;  bus.a_s = '0;  bus.a_d = '0;  bus.a_mode = '0;
      bus.b_p = '0;  bus.b_s = '0;  bus.b_d = '0;  bus.b_mode = '0;
`ifdef ROP3_ARB_STATS_EN
      bus.cnt_clr = 1'b0;
`endif
      do_reset(3);
      $display("[TB] A alone after reset");
      apply_stimulus(1, 0, 0, 8'h0F, 8'h33, 8'h55, 8'h96, 0, 0, 0, 0);
      idle(3);

      $display("[TB] Both valid, alternating grants");
      repeat (6) apply_stimulus(1, 1, 0, 8'hF0, 8'hCC, 8'h00, 8'hC0,
                                8'h00, 8'h0F, 8'hFF, 8'h66);
      idle(3);

      $display("[TB] Hold with an op in flight");
      apply_stimulus(1, 0, 0, 8'h3C, 8'h5A, 8'h99, 8'hE8, 0, 0, 0, 0);
      repeat (3) apply_stimulus(1, 1, 1, 8'h11, 8'h22, 8'h33, 8'hFF,
                                8'h44, 8'h55, 8'h66, 8'h0F);
      apply_stimulus(1, 1, 0, 8'h11, 8'h22, 8'h33, 8'hFF, 8'h44, 8'h55, 8'h66, 8'h0F);
      idle(3);

      $display("[TB] Reset one cycle after an issue");
      apply_stimulus(1, 0, 0, 8'hAA, 8'hBB, 8'hCC, 8'h96, 0, 0, 0, 0);
      do_reset(2);
      apply_stimulus(0, 1, 0, 0, 0, 0, 0, 8'h00, 8'hA5, 8'h00, 8'hCC);
      idle(3);

      $display("[TB] Randomized traffic");
      for (int i = 0; i < 500; i++) begin
         if ($urandom_range(0, 199) == 0) begin
            do_reset(2);
         end else begin
            apply_stimulus($urandom_range(0, 1), $urandom_range(0, 1),
                           ($urandom_range(0, 7) == 0),
                           8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
                           8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
         end
      end
      idle(4);

`ifdef ROP3_ARB_STATS_EN
      $display("[TB] Counter saturation and clear");
      do_reset(2);
      for (int i = 0; i < 70000; i++) begin
         apply_stimulus(1, 0, 0, 8'($urandom), 8'($urandom), 8'($urandom), 8'hCC, 0, 0, 0, 0);
      end
      idle(1);
      check("cnt_a_saturated", bus.cnt_a, 16'hFFFF);
      bus.cnt_clr = 1'b1;
      apply_stimulus(1, 0, 0, 8'h01, 8'h02, 8'h03, 8'hCC, 0, 0, 0, 0);
      bus.cnt_clr = 1'b0;
      idle(1);
      check("cnt_a_cleared", bus.cnt_a, 16'h0000);
      idle(3);
`endif

      check("scoreboard_drained", sb.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/rop3_arb2.md
Name: rop3_arb2

Overview:
- Two-requester round-robin arbiter and scheduler that shares one registered ROP3 LUT datapath (N-bit P/S/D, 8-bit Mode, fixed 2-cycle latency) between requester A and requester B.
- Accepts one operation per cycle over valid/ready, muxes the winner onto the datapath, and tracks in-flight operations with a tag pipeline.
- Returns each result to its originator as a one-cycle valid pulse aligned with the datapath Result.
- Sits between the blitter front-ends and the single ROP3 instance.

Parameters:
- N, 8, bit width of P, S, D and result.
- LAT, 2, datapath latency in cycles from issue to Result; fixed at 2, must match the datapath.

Ports:
- clk  in  1  system clock; all flops on posedge.
- reset  in  1  asynchronous, active-high reset.
- hold  in  1  when 1, no new grants are issued; in-flight operations still complete.
- a_valid / b_valid  in  1  requester has an operation pending.
- a_ready / b_ready  out  1  grant; transfer occurs on valid && ready.
- a_p, a_s, a_d / b_p, b_s, b_d  in  N  operands.
- a_mode / b_mode  in  8  ROP3 mode code.
- rop_p, rop_s, rop_d  out  N  operands to datapath.
- rop_mode  out  8  mode to datapath.
- rop_result  in  N  datapath Result, registered inside the datapath.
- rsp_a_valid / rsp_b_valid  out  1  result for A or B is valid this cycle.
- rsp_data  out  N  equals rop_result; meaningful only when an rsp_*_valid is high.

Behaviour:
- Reset (async): last_gnt = B, so A wins the first tie. Tag pipeline valids = 0. rsp_a_valid = rsp_b_valid = 0. Counters = 0 when the optional feature is enabled.
- Grant logic is combinational:
  - hold = 1: a_ready = b_ready = 0.
  - Only one valid: that requester is granted.
  - Both valid: the requester that is not last_gnt is granted.
  - Neither valid: no grant.
  - At most one ready is high in any cycle. ready never depends on a requester's own valid except through the arbitration above.
- Issue: rop_* carry the granted requester's operands. With no grant, rop_p, rop_s, rop_d, rop_mode = 0. Mode 0 produces a zero result, which is harmless.
- last_gnt updates on the clock edge only when a transfer occurs. No transfer means no change.
- Tag pipeline: stage0 = {vld, id}, captured at the edge ending issue cycle t; stage1 is stage0 delayed by one cycle.
  - rsp_x_valid = stage1.vld && stage1.id == x, so it is high in cycle t+2, aligned with rop_result for that operation.
  - Throughput is 1 op/cycle. Back-to-back alternating grants (A, B, A, B) give responses in the same order.
- There is no result backpressure; requesters must always sink responses.
- hold asserted with operations in flight: they drain and their responses appear on schedule.
- Reset mid-operation: in-flight tags are cleared and no response is produced for them. The datapath is not reset, so its registers may hold stale values; these are ignored because no rsp valid is asserted.
- A requester may deassert valid before it is granted; no state change results.

Optional Feature:
- Macro ROP3_ARB_STATS_EN.
- Defined:
  - Adds outputs cnt_a and cnt_b, 16 bits each.
  - Each counts transfers for its requester and saturates at 16'hFFFF.
  - Adds input cnt_clr; when 1 it synchronously zeros both counters, taking priority over an increment in the same cycle.
  - Both counters also reset asynchronously to 0.
- Undefined: these ports and the counter logic are absent. Arbitration timing is identical in both builds.

Decomposition:
- Package rop3_arb_pkg:
  - localparam ROP3_LAT = 2.
  - Requester id typedef: 1-bit enum REQ_A = 0, REQ_B = 1.
  - Tag struct {logic vld; req_id_t id;}.
- Sub-module rr_arb2:
  - Inputs: req[1:0], hold, accept.
  - Outputs: gnt[1:0] one-hot, gnt_id.
  - Owns the last_gnt flop.
  - The top level holds the operand mux, the tag pipeline and the stats counters.

Test Plan:
- After reset, A only: a_p = 8'h0F, a_s = 8'h33, a_d = 8'h55, a_mode = 8'h96 accepted at cycle t -> rsp_a_valid = 1 and rsp_data = 8'h69 at t+2; rsp_b_valid stays 0.
- A and B both valid every cycle: grants alternate A, B, A, B starting with A. A uses mode 8'hC0 (P = 8'hF0, S = 8'hCC) -> 8'hC0. B uses mode 8'h66 (S = 8'h0F, D = 8'hFF) -> 8'hF0. Responses alternate with a 2-cycle offset from their grants.
- hold = 1 while both are valid -> both ready = 0 and rop_mode = 0. An op issued the cycle before hold rises still returns its rsp valid two cycles after its issue.
- Reset asserted one cycle after an issue -> no rsp valid for that op. After release, B alone with mode 8'hCC and S = 8'hA5 -> rsp_b_valid and rsp_data = 8'hA5.
- ROP3_ARB_STATS_EN: 70000 back-to-back A transfers -> cnt_a saturates at 16'hFFFF. Then cnt_clr = 1 in the same cycle as an A transfer -> cnt_a = 0.
